// File: rtl/al_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : al_flush_ctrl
//  Purpose  : Active-list pointer owner and mispredict-flush sequencer.
//             Keeps head (commit side), tail (dispatch side) and per-entry
//             valid bits. On an accepted branch flush it emits a one-shot
//             squash mask, rewinds tail, then walks the squashed entries
//             youngest-first, one per cycle, so rename can free registers.
//  Ports    : clk, rst_n           clock, synchronous active-low reset
//             alloc_valid/ready    dispatch allocation handshake
//             alloc_idx            entry granted (current tail)
//             commit_valid         retire head entry
//             flush_req/flush_idx  mispredict request and its AL index
//             flush_mask           one-cycle squash mask
//             flush_busy           walk in progress
//             walk_valid/walk_idx  squashed entry to release
//             flush_done           one-cycle flush completion pulse
//             flush_err            one-cycle pulse for a dropped request
//             valid_vec            per-entry occupancy
//             head, tail, count    pointers and occupancy
//             empty, full          occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module al_flush_ctrl #(
  parameter  int AL_SIZE = 32,
  localparam int IDX_W   = $clog2(AL_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic               commit_valid,
  input  logic               flush_req,
  input  logic [IDX_W-1:0]   flush_idx,
  output logic [AL_SIZE-1:0] flush_mask,
  output logic               flush_busy,
  output logic               walk_valid,
  output logic [IDX_W-1:0]   walk_idx,
  output logic               flush_done,
  output logic               flush_err,
  output logic [AL_SIZE-1:0] valid_vec,
  output logic [IDX_W-1:0]   head,
  output logic [IDX_W-1:0]   tail,
  output logic [IDX_W:0]     count,
  output logic               empty,
  output logic               full
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   head_nxt, tail_nxt, walk_idx_nxt;
  logic [CNT_W-1:0]   count_nxt, walk_rem, walk_rem_nxt;
  logic [CNT_W-1:0]   k_val, n_val;
  logic [AL_SIZE-1:0] valid_nxt, sq_mask, flush_mask_nxt;
  logic               walk_valid_nxt, busy_nxt, done_nxt, err_nxt;
  logic               do_alloc, do_commit, flush_acc;

  assign full        = (count == CNT_W'(AL_SIZE));
  assign empty       = (count == '0);
  assign alloc_idx   = tail;
  assign alloc_ready = !full && (state == IDLE) && !flush_req;
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_commit   = commit_valid && !empty;
  assign flush_acc   = flush_req && (state == IDLE) && valid_vec[flush_idx];

  // K = surviving entries (head..flush_idx inclusive), N = squashed entries.
  // N derives from count so the full case (head==tail) is handled correctly.
  assign k_val = {1'b0, flush_idx - head} + CNT_W'(1);
  assign n_val = count - k_val;

  // Entry i is squashed when its age offset from head lies in [K, count).
  for (genvar i = 0; i < AL_SIZE; i++) begin : g_sq_mask
    logic [IDX_W-1:0] off;
    assign off        = IDX_W'(i) - head;
    assign sq_mask[i] = ({1'b0, off} >= k_val) && ({1'b0, off} < count);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid_vec  <= '0;
      flush_mask <= '0;
      walk_valid <= 1'b0;
      walk_idx   <= '0;
      walk_rem   <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      flush_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      head       <= head_nxt;
      tail       <= tail_nxt;
      count      <= count_nxt;
      valid_vec  <= valid_nxt;
      flush_mask <= flush_mask_nxt;
      walk_valid <= walk_valid_nxt;
      walk_idx   <= walk_idx_nxt;
      walk_rem   <= walk_rem_nxt;
      flush_busy <= busy_nxt;
      flush_done <= done_nxt;
      flush_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    head_nxt       = head;
    tail_nxt       = tail;
    count_nxt      = count;
    valid_nxt      = valid_vec;
    flush_mask_nxt = '0;
    walk_valid_nxt = walk_valid;
    walk_idx_nxt   = walk_idx;
    walk_rem_nxt   = walk_rem;
    busy_nxt       = flush_busy;
    done_nxt       = 1'b0;
    err_nxt        = flush_req && !flush_acc;

    // Head is never squashed (offset 0 < K), so commit and flush are disjoint.
    if (do_commit) begin
      valid_nxt[head] = 1'b0;
      head_nxt        = head + IDX_W'(1);
      count_nxt       = count_nxt - CNT_W'(1);
    end

    // alloc_ready excludes flush_req, so allocation never overlaps a flush.
    if (do_alloc) begin
      valid_nxt[tail] = 1'b1;
      tail_nxt        = tail + IDX_W'(1);
      count_nxt       = count_nxt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (flush_acc) begin
          tail_nxt       = flush_idx + IDX_W'(1);
          valid_nxt      = valid_nxt & ~sq_mask;
          count_nxt      = count_nxt - n_val;
          flush_mask_nxt = sq_mask;
          if (n_val == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt      = WALK;
            walk_valid_nxt = 1'b1;
            busy_nxt       = 1'b1;
            walk_idx_nxt   = tail - IDX_W'(1);
            // walk_rem counts entries still to present after the current one.
            walk_rem_nxt   = n_val - CNT_W'(1);
            done_nxt       = (n_val == CNT_W'(1));
          end
        end
      end
      WALK: begin
        if (walk_rem == '0) begin
          state_nxt      = IDLE;
          walk_valid_nxt = 1'b0;
          busy_nxt       = 1'b0;
        end else begin
          walk_idx_nxt = walk_idx - IDX_W'(1);
          walk_rem_nxt = walk_rem - CNT_W'(1);
          done_nxt     = (walk_rem == CNT_W'(1));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_al_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_al_flush_ctrl
//  Purpose  : Directed self-checking bench for al_flush_ctrl (AL_SIZE=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_al_flush_ctrl;

  localparam int AL_SIZE = 32;
  localparam int IDX_W   = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               alloc_valid;
  logic               alloc_ready;
  logic [IDX_W-1:0]   alloc_idx;
  logic               commit_valid;
  logic               flush_req;
  logic [IDX_W-1:0]   flush_idx;
  logic [AL_SIZE-1:0] flush_mask;
  logic               flush_busy;
  logic               walk_valid;
  logic [IDX_W-1:0]   walk_idx;
  logic               flush_done;
  logic               flush_err;
  logic [AL_SIZE-1:0] valid_vec;
  logic [IDX_W-1:0]   head;
  logic [IDX_W-1:0]   tail;
  logic [IDX_W:0]     count;
  logic               empty;
  logic               full;

  int checks   = 0;
  int failures = 0;

  al_flush_ctrl #(.AL_SIZE(AL_SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_idx    (alloc_idx),
    .commit_valid (commit_valid),
    .flush_req    (flush_req),
    .flush_idx    (flush_idx),
    .flush_mask   (flush_mask),
    .flush_busy   (flush_busy),
    .walk_valid   (walk_valid),
    .walk_idx     (walk_idx),
    .flush_done   (flush_done),
    .flush_err    (flush_err),
    .valid_vec    (valid_vec),
    .head         (head),
    .tail         (tail),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    alloc_valid = 1'b0;
  endtask

  task automatic commit_n(input int n);
    commit_valid = 1'b1;
    for (int i = 0; i < n; i++) tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    alloc_valid  = 1'b0;
    commit_valid = 1'b0;
    flush_req    = 1'b0;
    flush_idx    = '0;
    tick();
    tick();

    // ---------------- reset state
    chk("rst_head",  head, 0);
    chk("rst_tail",  tail, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", valid_vec, 0);
    chk("rst_mask",  flush_mask, 0);
    chk("rst_walk",  {walk_valid, walk_idx}, 0);
    chk("rst_flags", {flush_busy, flush_done, flush_err}, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);

    // ---------------- 32 allocations, no commit
    alloc_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("fill_idx",   alloc_idx, i);
      chk("fill_ready", alloc_ready, 1);
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    chk("fill_full",  full, 1);
    chk("fill_ready_lo", alloc_ready, 0);
    chk("fill_count", count, 32);
    chk("fill_ptrs",  {head, tail}, 0);
    chk("fill_valid", valid_vec, 32'hFFFF_FFFF);

    // ---------------- full-list flush at head with same-cycle commit
    commit_n(10);
    alloc_n(10);
    chk("full_head",  head, 10);
    chk("full_tail",  tail, 10);
    chk("full_count", count, 32);
    flush_req    = 1'b1;
    flush_idx    = 5'd10;
    commit_valid = 1'b1;
    tick();
    flush_req    = 1'b0;
    commit_valid = 1'b0;
    #1;
    chk("full_mask",   flush_mask, 32'hFFFF_FBFF);
    chk("full_count0", count, 0);
    chk("full_empty",  empty, 1);
    chk("full_ptrs",   {head, tail}, {5'd11, 5'd11});
    chk("full_valid",  valid_vec, 0);
    chk("full_ready",  alloc_ready, 0);
    for (int j = 0; j < 31; j++) begin
      chk("full_wv",   walk_valid, 1);
      chk("full_busy", flush_busy, 1);
      chk("full_widx", walk_idx, (9 - j) & 31);
      chk("full_done", flush_done, (j == 30));
      if (j == 1) chk("full_mask_oneshot", flush_mask, 0);
      if (j == 3) chk("walk_err", flush_err, 1);
      if (j == 4) chk("walk_err_clr", flush_err, 0);
      flush_req = (j == 2);
      flush_idx = '0;
      tick();
    end
    flush_req = 1'b0;
    #1;
    chk("full_end_wv",   {walk_valid, flush_busy, flush_done}, 0);
    chk("full_end_ready", alloc_ready, 1);

    // ---------------- wrap flush: head=28 tail=4, flush_idx=30
    alloc_n(17);
    commit_n(17);
    alloc_n(8);
    chk("wrap_head",  head, 28);
    chk("wrap_tail",  tail, 4);
    chk("wrap_count", count, 8);
    chk("wrap_valid", valid_vec, 32'hF000_000F);
    flush_req = 1'b1;
    flush_idx = 5'd30;
    tick();
    flush_req = 1'b0;
    chk("wrap_mask",  flush_mask, 32'h8000_000F);
    chk("wrap_tail2", tail, 31);
    chk("wrap_count2", count, 3);
    chk("wrap_valid2", valid_vec, 32'h7000_0000);
    for (int j = 0; j < 5; j++) begin
      chk("wrap_wv",   walk_valid, 1);
      chk("wrap_widx", walk_idx, (3 - j) & 31);
      chk("wrap_done", flush_done, (j == 4));
      commit_valid = (j == 1);
      tick();
    end
    commit_valid = 1'b0;
    chk("wrap_end_wv", walk_valid, 0);
    chk("wrap_end_ptrs", {head, tail}, {5'd29, 5'd31});
    chk("wrap_end_count", count, 2);

    // ---------------- youngest-entry flush: head=5 tail=9 flush_idx=8
    commit_n(2);
    alloc_n(6);
    commit_n(6);
    alloc_n(4);
    chk("young_ptrs", {head, tail}, {5'd5, 5'd9});
    flush_req = 1'b1;
    flush_idx = 5'd8;
    tick();
    flush_req = 1'b0;
    #1;
    chk("young_mask", flush_mask, 0);
    chk("young_wv",   {walk_valid, flush_busy}, 0);
    chk("young_done", flush_done, 1);
    chk("young_ready", alloc_ready, 1);
    chk("young_tc",   {tail, count}, {5'd9, 6'd4});
    tick();
    chk("young_done_clr", flush_done, 0);

    // ---------------- flush at an invalid index
    flush_req = 1'b1;
    flush_idx = 5'd12;
    tick();
    flush_req = 1'b0;
    chk("inv_err",   flush_err, 1);
    chk("inv_ptrs",  {head, tail, count}, {5'd5, 5'd9, 6'd4});
    chk("inv_quiet", {flush_mask, flush_done, walk_valid}, 0);
    tick();
    chk("inv_err_clr", flush_err, 0);

    // ---------------- commit while empty
    commit_n(4);
    chk("drain_empty", empty, 1);
    commit_n(1);
    chk("empty_commit", {head, tail, count}, {5'd9, 5'd9, 6'd0});
    chk("empty_valid", valid_vec, 0);

    // ---------------- reset in the 2nd cycle of a 6-entry walk
    alloc_n(8);
    flush_req = 1'b1;
    flush_idx = 5'd10;
    tick();
    flush_req = 1'b0;
    chk("rw_mask", flush_mask, 32'h0001_F800);
    chk("rw_widx1", walk_idx, 16);
    tick();
    chk("rw_widx2", {walk_valid, walk_idx}, {1'b1, 5'd15});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rw_ptrs",  {head, tail, count}, 0);
    chk("rw_valid", valid_vec, 0);
    chk("rw_walk",  {flush_mask, walk_valid, walk_idx, flush_busy, flush_done, flush_err}, 0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rw_no_done", {flush_done, walk_valid}, 0);
    end
    chk("rw_empty", {empty, alloc_ready}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
